t03_nes_multipad_reader: RTL and testbench
==========================================

# t03_nes_multipad_reader

Parametrised serial game-pad reader: generates the shared latch/clock strobes for up to four NES- or SNES-style pads, shifts in every pad's serial data each frame, and presents debounced-by-frame button words plus newly-pressed edges. Successor to the single-pad NES clock-divider/counter. Sits between the pad I/O pins and the game logic, all in the system clock domain.

## Interface
- NUM_PADS, 2, pads read in parallel (1–4)
- NUM_BITS, 8, bits per pad (8 = NES, 16 = SNES)
- CLK_DIV, 16, clk cycles per tick (≥2)
- LATCH_TICKS, 30, ticks pad_latch is high
- HALF_TICKS, 15, ticks per pad_clk low and per high phase
- FRAME_TICKS, 41667, ticks per frame; must be ≥ LATCH_TICKS + 2·HALF_TICKS·NUM_BITS + 1
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- enable  in  1  permits new frames to start
- pad_data  in  NUM_PADS  serial data from each pad, active-low (0 = pressed)
- pad_latch  out  1  shared latch strobe
- pad_clk  out  1  shared shift clock, idle low
- buttons  out  NUM_PADS·NUM_BITS  active-high; pad p bit i at [p·NUM_BITS+i]
- pressed  out  NUM_PADS·NUM_BITS  buttons & ~previous buttons
- buttons_valid  out  1  one-clk pulse when buttons/pressed update
- busy  out  1  frame in progress

## Operation
- Reset: all outputs 0, state IDLE, prescaler 0, frame counter 0, synchronisers 0 (pads read "pressed" only after resync; first frame overwrites).
- Prescaler counts 0..CLK_DIV-1; tick = (prescaler == CLK_DIV-1). Frame counter advances on tick, wraps FRAME_TICKS-1 → 0; free-running regardless of enable.
- pad_data passes through a 2-flop synchroniser per pad, then inverted.
- FSM, transitions only on tick:
  - IDLE: if frame counter == 0 and enable → LATCH.
  - LATCH: pad_latch=1 for LATCH_TICKS ticks → LOW.
  - LOW: pad_clk=0 for HALF_TICKS ticks; on last LOW tick sample every synchronised pad bit into shift register position bit_idx → HIGH.
  - HIGH: pad_clk=1 for HALF_TICKS ticks; then bit_idx+1; if bit_idx was NUM_BITS-1 → DONE else → LOW.
  - DONE: one clk; buttons ← shift regs, pressed ← shift & ~old buttons, buttons_valid=1 → IDLE.
- busy = 1 in LATCH/LOW/HIGH/DONE.
- enable dropped mid-frame: frame completes normally; no new frame. enable raised mid-period: waits for next frame counter wrap.
- NUM_BITS pulses per frame (the last is harmless to pads).
- Reset mid-frame: immediate return to reset values; pad_latch/pad_clk drop asynchronously.
- Widths: prescaler $clog2(CLK_DIV); phase counter $clog2(max(LATCH_TICKS,HALF_TICKS)); bit_idx $clog2(NUM_BITS); frame counter $clog2(FRAME_TICKS). No arithmetic wraps other than those stated.

## Timing
- pad_latch, pad_clk, busy registered; change on the clk edge ending a tick cycle.
- After nrst release with enable=1: first tick at cycle CLK_DIV-1, pad_latch rises at edge CLK_DIV.
- Sample of bit i occurs at tick LATCH_TICKS + i·2·HALF_TICKS + HALF_TICKS-1 counted from LATCH entry.
- buttons_valid high for exactly one clk, one clk after the final HIGH tick; buttons/pressed change on that same edge and hold until next valid.
- Frame-to-frame period exactly FRAME_TICKS·CLK_DIV clk cycles while enable held.

## Structure
- Package t03_nes_pkg: state enum (IDLE, LATCH, LOW, HIGH, DONE), constants NES_BITS=8, SNES_BITS=16, default timing constants.
- Sub-module t03_nes_tick_gen: prescaler + frame counter, outputs tick and frame_start; parameters CLK_DIV, FRAME_TICKS.
- Elaboration-time check of the FRAME_TICKS inequality.

## Test plan
Sim params: NUM_PADS=2, NUM_BITS=8, CLK_DIV=2, LATCH_TICKS=4, HALF_TICKS=2, FRAME_TICKS=64.
- Reset then enable=1, pads idle high → pad_latch high clk 2–9, eight pad_clk pulses of 4 clk high, buttons_valid at clk 74, buttons=0x0000.
- Pad0 model returns 0xA5 (bit0 first, active-low), pad1 0x3C → buttons=0x3CA5, pressed=0x3CA5; next frame same data → pressed=0x0000, period 128 clk.
- Pad0 changes 0xA5→0xA7 → pressed=0x0002 only.
- enable dropped during LOW of bit 3 → frame completes, valid pulses once, no further latch until enable re-raised and next wrap.
- nrst asserted during HIGH phase → pad_clk, pad_latch, buttons, busy 0 immediately; restart timing identical to first scenario.
- NUM_BITS=16, NUM_PADS=4 build → sixteen pulses, 64-bit buttons mapped per [p·16+i].

Source files
------------

// File: rtl/t03_nes_pkg.sv
// Shared types and constants for the multi-pad NES/SNES serial reader.
package t03_nes_pkg;

  // Reader FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } nes_state_e;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  // Default timing: 16 clk per tick, 60 Hz frame at a 40 MHz system clock.
  localparam int DEF_CLK_DIV     = 16;
  localparam int DEF_LATCH_TICKS = 30;
  localparam int DEF_HALF_TICKS  = 15;
  localparam int DEF_FRAME_TICKS = 41667;

  // Shortest frame that still holds latch, every clock pulse and the DONE cycle.
  function automatic int min_frame_ticks(input int latch_ticks, input int half_ticks,
                                         input int num_bits);
    return latch_ticks + 2 * half_ticks * num_bits + 1;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t03_nes_tick_gen.sv
// Prescaler producing a one-clk tick every CLK_DIV cycles, plus a free-running
// frame counter in ticks whose zero count marks the start of a frame.
module t03_nes_tick_gen
  import t03_nes_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
  input  logic clk,
  input  logic nrst,
  output logic tick,
  output logic frame_start
);

  localparam int PW = cnt_width(CLK_DIV);
  localparam int FW = cnt_width(FRAME_TICKS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);

  logic [PW-1:0] pre_q;
  logic [FW-1:0] frame_q;

  assign tick        = (pre_q == PRE_LAST);
  assign frame_start = tick && (frame_q == '0);

  // Prescaler and frame counter; both run regardless of enable.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pre_q   <= '0;
      frame_q <= '0;
    end else begin
      if (tick) begin
        pre_q   <= '0;
        frame_q <= (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/t03_nes_multipad_reader.sv
// Reads up to four NES/SNES pads in parallel over a shared latch/clock pair and
// publishes the frame's button words plus newly-pressed edges.
//
// buttons_valid is a one-clk strobe with no back-pressure: buttons and pressed
// change on the same edge that raises it and hold until the next strobe.
module t03_nes_multipad_reader
  import t03_nes_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = NES_BITS,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int LATCH_TICKS = DEF_LATCH_TICKS,
  parameter int HALF_TICKS  = DEF_HALF_TICKS,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic                         buttons_valid,
  output logic                         busy,
  output nes_state_e                   fsm_state
);

  localparam int TW  = NUM_PADS * NUM_BITS;
  localparam int PHW = cnt_width((LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS);
  localparam int BW  = cnt_width(NUM_BITS);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_TICKS - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_TICKS - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(NUM_BITS - 1);

  // Reject parameter sets that cannot fit a full read inside one frame.
  if (FRAME_TICKS < min_frame_ticks(LATCH_TICKS, HALF_TICKS, NUM_BITS)) begin : g_bad_frame
    $error("FRAME_TICKS too small for LATCH_TICKS/HALF_TICKS/NUM_BITS");
  end
  if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
    $error("NUM_PADS must be 1..4");
  end
  if (NUM_BITS < 1 || NUM_BITS > SNES_BITS) begin : g_bad_bits
    $error("NUM_BITS must be 1..16");
  end
  if (CLK_DIV < 2 || LATCH_TICKS < 1 || HALF_TICKS < 1) begin : g_bad_timing
    $error("CLK_DIV must be >= 2 and LATCH_TICKS/HALF_TICKS >= 1");
  end

  logic tick;
  logic frame_start;

  t03_nes_tick_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_TICKS(FRAME_TICKS)
  ) u_tick_gen (
    .clk        (clk),
    .nrst       (nrst),
    .tick       (tick),
    .frame_start(frame_start)
  );

  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  logic [NUM_PADS-1:0] pad_bits;
  nes_state_e          state_q, state_d;
  logic [PHW-1:0]      phase_q, phase_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                sample;
  logic                finish;
  logic [TW-1:0]       shift_q, shift_d;

  // Pad lines are asynchronous to clk and active-low.
  assign pad_bits  = ~sync2_q;
  assign fsm_state = state_q;

  // Two-flop synchroniser per pad.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_data;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, phase counter and bit index registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic: every phase advances on ticks only, DONE lasts one clk.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sample  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          state_d = LATCH;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      LATCH: begin
        if (tick) begin
          if (phase_q == LATCH_LAST) begin
            state_d = LOW;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      LOW: begin
        if (tick) begin
          if (phase_q == HALF_LAST) begin
            sample  = 1'b1;
            state_d = HIGH;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      HIGH: begin
        if (tick) begin
          if (phase_q == HALF_LAST) begin
            phase_d = '0;
            if (bit_q == BIT_LAST) begin
              state_d = DONE;
              finish  = 1'b1;
            end else begin
              state_d = LOW;
              bit_d   = bit_q + 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drop each pad's synchronised bit into its slot at the current bit index.
  always_comb begin
    shift_d = shift_q;
    if (sample) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int i = 0; i < NUM_BITS; i++) begin
          if (BW'(i) == bit_q) shift_d[p*NUM_BITS + i] = pad_bits[p];
        end
      end
    end
  end

  // Registered pad strobes, status and published button words.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_q       <= '0;
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b0;
      busy          <= 1'b0;
      buttons_valid <= 1'b0;
      buttons       <= '0;
      pressed       <= '0;
    end else begin
      shift_q       <= shift_d;
      pad_latch     <= (state_d == LATCH);
      pad_clk       <= (state_d == HIGH);
      busy          <= (state_d != IDLE);
      buttons_valid <= finish;
      if (finish) begin
        buttons <= shift_q;
        pressed <= shift_q & ~buttons;
      end
    end
  end

endmodule

// File: tb/tb_t03_nes_multipad_reader.sv
// Directed-sequence bench with a behavioural NES pad model and a scoreboard of
// expected button words; timing is measured in clk edges since reset release.
module tb_t03_nes_multipad_reader;
  import t03_nes_pkg::*;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int CD = 2;
  localparam int LT = 4;
  localparam int HT = 2;
  localparam int FT = 64;
  localparam int TW = NP * NB;
  localparam int PERIOD     = FT * CD;
  localparam int LATCH_RISE = CD;
  localparam int LATCH_FALL = CD + LT * CD;
  localparam int VALID_CYC  = CD + (LT + 2 * HT * NB) * CD;
  localparam int PULSE_W    = HT * CD;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          nrst;
  logic          enable;
  logic [NP-1:0] pad_data;
  logic          pad_latch;
  logic          pad_clk;
  logic [TW-1:0] buttons;
  logic [TW-1:0] pressed;
  logic          buttons_valid;
  logic          busy;
  nes_state_e    fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  t03_nes_multipad_reader #(
    .NUM_PADS   (NP),
    .NUM_BITS   (NB),
    .CLK_DIV    (CD),
    .LATCH_TICKS(LT),
    .HALF_TICKS (HT),
    .FRAME_TICKS(FT)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .enable       (enable),
    .pad_data     (pad_data),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .buttons      (buttons),
    .pressed      (pressed),
    .buttons_valid(buttons_valid),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // ---------------- pad model ----------------
  // A real pad presents bit 0 while latched and advances one bit per rising clock.
  logic [NB-1:0] word [NP];
  logic [4:0]    pad_idx = 5'(NB);

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx = 5'd0;
    else if (pad_idx < 5'(NB)) pad_idx = pad_idx + 5'd1;
  end

  always_comb begin
    pad_data = '1;
    for (int p = 0; p < NP; p++) begin
      if (pad_idx < 5'(NB)) pad_data[p] = ~word[p][pad_idx[2:0]];
    end
  end

  // ---------------- edge monitor ----------------
  int   cyc = 0;
  int   latch_rises = 0, latch_rise_cyc = 0, latch_fall_cyc = 0;
  int   clk_rises_f = 0, clk_falls_f = 0, clk_rise_at = 0, min_w = 0, max_w = 0;
  int   valid_count = 0, valid_cyc = 0, prev_valid_cyc = 0, valid_long = 0;
  logic prev_latch = 1'b0, prev_pclk = 1'b0, prev_valid = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!nrst) begin
      cyc        = 0;
      prev_latch = 1'b0;
      prev_pclk  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      cyc++;
      if (pad_latch && !prev_latch) begin
        latch_rises++;
        latch_rise_cyc = cyc;
        clk_rises_f    = 0;
        clk_falls_f    = 0;
        min_w          = 1000;
        max_w          = 0;
      end
      if (!pad_latch && prev_latch) latch_fall_cyc = cyc;
      if (pad_clk && !prev_pclk) begin
        clk_rises_f++;
        clk_rise_at = cyc;
      end
      if (!pad_clk && prev_pclk) begin
        clk_falls_f++;
        if (cyc - clk_rise_at < min_w) min_w = cyc - clk_rise_at;
        if (cyc - clk_rise_at > max_w) max_w = cyc - clk_rise_at;
      end
      if (buttons_valid) begin
        if (prev_valid) valid_long++;
        valid_count++;
        prev_valid_cyc = valid_cyc;
        valid_cyc      = cyc;
      end
      prev_latch = pad_latch;
      prev_pclk  = pad_clk;
      prev_valid = buttons_valid;
    end
  end

  // ---------------- scoreboard ----------------
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] last_exp = '0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_frame(input logic [TW-1:0] w);
    for (int p = 0; p < NP; p++) word[p] = w[p*NB +: NB];
    exp_q.push_back(w);
  endtask

  task automatic wait_valid(input string tag);
    int start;
    int n;
    logic [TW-1:0] exp;
    start = valid_count;
    n = 0;
    while (valid_count == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, 64'(valid_count - start), 64'd1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = '0;
    check({tag, "_buttons"}, 64'(buttons), 64'(exp));
    check({tag, "_pressed"}, 64'(pressed), 64'(exp & ~last_exp));
    last_exp = exp;
  endtask

  task automatic check_frame_shape(input string tag);
    check({tag, "_pulses"}, 64'(clk_falls_f), 64'(NB));
    check({tag, "_min_w"}, 64'(min_w), 64'(PULSE_W));
    check({tag, "_max_w"}, 64'(max_w), 64'(PULSE_W));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lr;
    int vc;
    int n;
    logic [TW-1:0] rw;

    nrst   = 1'b0;
    enable = 1'b0;
    for (int p = 0; p < NP; p++) word[p] = '0;
    idle_cycles(3);

    // Reset state.
    check("rst_latch", 64'(pad_latch), 64'd0);
    check("rst_clk", 64'(pad_clk), 64'd0);
    check("rst_buttons", 64'(buttons), 64'd0);
    check("rst_pressed", 64'(pressed), 64'd0);
    check("rst_valid", 64'(buttons_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(IDLE));

    // First frame, pads idle.
    enable = 1'b1;
    nrst   = 1'b1;
    expect_frame('0);
    wait_valid("f0");
    check("f0_latch_rise", 64'(latch_rise_cyc), 64'(LATCH_RISE));
    check("f0_latch_fall", 64'(latch_fall_cyc), 64'(LATCH_FALL));
    check("f0_valid_cyc", 64'(valid_cyc), 64'(VALID_CYC));
    check_frame_shape("f0");
    @(negedge clk);
    check("f0_valid_drop", 64'(buttons_valid), 64'd0);
    check("f0_busy_drop", 64'(busy), 64'd0);

    // Directed patterns.
    expect_frame(16'h3CA5);
    wait_valid("f1");
    check("f1_period", 64'(valid_cyc - prev_valid_cyc), 64'(PERIOD));
    check_frame_shape("f1");
    expect_frame(16'h3CA5);
    wait_valid("f2");
    check("f2_period", 64'(valid_cyc - prev_valid_cyc), 64'(PERIOD));
    expect_frame(16'h3CA7);
    wait_valid("f3");

    // Random pads.
    for (int k = 0; k < 5; k++) begin
      rw = TW'($urandom);
      expect_frame(rw);
      wait_valid("frand");
      check("frand_period", 64'(valid_cyc - prev_valid_cyc), 64'(PERIOD));
    end

    // Drop enable during the LOW phase of bit 3.
    rw = TW'($urandom);
    expect_frame(rw);
    lr = latch_rises;
    n = 0;
    while (!(latch_rises != lr && clk_falls_f == 3) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("en_drop_reached", 64'(clk_falls_f), 64'd3);
    check("en_drop_state", 64'(fsm_state), 64'(LOW));
    check("en_drop_busy", 64'(busy), 64'd1);
    enable = 1'b0;
    wait_valid("en_drop");
    check_frame_shape("en_drop");
    lr = latch_rises;
    vc = valid_count;
    idle_cycles(3 * PERIOD);
    check("en_off_no_latch", 64'(latch_rises - lr), 64'd0);
    check("en_off_no_valid", 64'(valid_count - vc), 64'd0);
    check("en_off_busy", 64'(busy), 64'd0);

    // Raise enable at a random point; frame must wait for the counter wrap.
    idle_cycles($urandom_range(0, PERIOD - 1));
    enable = 1'b1;
    rw = TW'($urandom);
    expect_frame(rw);
    wait_valid("en_raise");
    check("en_raise_phase", 64'(latch_rise_cyc % PERIOD), 64'(LATCH_RISE));

    // Reset during a HIGH phase.
    expect_frame(TW'($urandom));
    lr = latch_rises;
    n = 0;
    while (!(latch_rises != lr && pad_clk) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_in_high", 64'(fsm_state), 64'(HIGH));
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_clk", 64'(pad_clk), 64'd0);
    check("mid_rst_latch", 64'(pad_latch), 64'd0);
    check("mid_rst_buttons", 64'(buttons), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    last_exp = '0;
    idle_cycles(3);
    rw = TW'($urandom);
    expect_frame(rw);
    nrst = 1'b1;
    wait_valid("restart");
    check("restart_latch_rise", 64'(latch_rise_cyc), 64'(LATCH_RISE));
    check("restart_latch_fall", 64'(latch_fall_cyc), 64'(LATCH_FALL));
    check("restart_valid_cyc", 64'(valid_cyc), 64'(VALID_CYC));
    check_frame_shape("restart");

    check("valid_one_clk", 64'(valid_long), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
